// File: rtl/layernorm_stat_unit_pkg.sv
// Shared SIMD normalization definitions: fixed-point format, reciprocal-sqrt
// LUT select window and the layernorm statistics FSM states.
package layernorm_stat_unit_pkg;

  localparam int FRAC_BITS     = 16;
  localparam int ISQRT_SEL_LO  = 4;
  localparam int ISQRT_SEL_HI  = 15;
  localparam int ISQRT_SEL_LSB = 12;

  typedef enum logic [2:0] {
    ACC,
    CALC,
    LUT,
    CAPT,
    DONE
  } lnstat_state_t;

endpackage

// File: rtl/lnstat_accum.sv
// Running sum, sum of squares and element count for one layernorm vector.
module lnstat_accum
  import layernorm_stat_unit_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int VEC_LEN   = 64
) (
  input  logic                                          clk,
  input  logic                                          clear,
  input  logic                                          en,
  input  logic signed [BIT_WIDTH-1:0]                   data,
  output logic signed [BIT_WIDTH+$clog2(VEC_LEN)-1:0]   sum,
  output logic        [2*BIT_WIDTH+$clog2(VEC_LEN)-1:0] sumsq,
  output logic                                          last
);

  localparam int LG = $clog2(VEC_LEN);
  localparam int PW = 2 * BIT_WIDTH;

  logic        [LG-1:0] cnt;
  logic signed [PW-1:0] data_ext;
  logic        [PW-1:0] sq;

  assign data_ext = {{BIT_WIDTH{data[BIT_WIDTH-1]}}, data};
  assign sq       = data_ext * data_ext;
  assign last     = (cnt == LG'(VEC_LEN - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      sum   <= '0;
      sumsq <= '0;
      cnt   <= '0;
    end else if (en) begin
      sum   <= sum + {{LG{data[BIT_WIDTH-1]}}, data};
      sumsq <= sumsq + {{LG{1'b0}}, sq};
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/layernorm_stat_unit.sv
// Layernorm statistics: accumulates one vector, derives mean and variance,
// looks up 1/sqrt(var) in an external registered LUT and hands off the pair.
module layernorm_stat_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int VEC_LEN   = 64,
  parameter int FRAC_BITS = layernorm_stat_unit_pkg::FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] lut_in,
  input  logic [BIT_WIDTH-1:0] lut_out,
  output logic [BIT_WIDTH-1:0] out_mean,
  output logic [BIT_WIDTH-1:0] out_inv_std,
  output logic                 out_oor,
  output logic                 out_valid,
  input  logic                 out_ready
);

  import layernorm_stat_unit_pkg::*;

  localparam int LG   = $clog2(VEC_LEN);
  localparam int SW   = BIT_WIDTH + LG;
  localparam int QW   = 2 * BIT_WIDTH + LG;
  localparam int PW   = 2 * BIT_WIDTH;
  localparam int SELW = BIT_WIDTH - ISQRT_SEL_LSB;

  lnstat_state_t state, state_n;

  logic signed [SW-1:0]        sum;
  logic        [QW-1:0]        sumsq;
  logic                        last;
  logic                        en;
  logic                        clear;
  logic signed [BIT_WIDTH-1:0] mean_c;
  logic signed [PW-1:0]        mean_ext;
  logic signed [PW-1:0]        m2;
  logic signed [PW-1:0]        ex2;
  logic signed [PW-1:0]        var_s;
  logic        [BIT_WIDTH-1:0] var_c;
  logic        [BIT_WIDTH-1:0] var_q;
  logic        [SELW-1:0]      sel;
  logic                        oor_c;

  assign in_ready  = (state == ACC) && !reset;
  assign out_valid = (state == DONE);
  assign en        = in_valid && in_ready;
  assign clear     = reset || ((state == DONE) && out_ready);
  assign lut_in    = var_q;

  lnstat_accum #(
    .BIT_WIDTH (BIT_WIDTH),
    .VEC_LEN   (VEC_LEN)
  ) u_accum (
    .clk   (clk),
    .clear (clear),
    .en    (en),
    .data  (in_data),
    .sum   (sum),
    .sumsq (sumsq),
    .last  (last)
  );

  assign mean_c   = BIT_WIDTH'(sum >>> LG);
  assign mean_ext = {{BIT_WIDTH{mean_c[BIT_WIDTH-1]}}, mean_c};
  assign m2       = (mean_ext * mean_ext) >>> FRAC_BITS;
  assign ex2      = PW'(sumsq >> (FRAC_BITS + LG));
  assign var_s    = ex2 - m2;

  // Negative variance only comes from truncation; clamp low, saturate high.
  always_comb begin
    var_c = var_s[BIT_WIDTH-1:0];
    if (var_s[PW-1]) begin
      var_c = '0;
    end else if (|var_s[PW-2:BIT_WIDTH]) begin
      var_c = '1;
    end
  end

  assign sel   = var_q[BIT_WIDTH-1:ISQRT_SEL_LSB];
  assign oor_c = (sel < SELW'(ISQRT_SEL_LO)) || (sel > SELW'(ISQRT_SEL_HI));

  always_comb begin
    state_n = state;
    case (state)
      ACC:     if (en && last) state_n = CALC;
      CALC:    state_n = LUT;
      LUT:     state_n = CAPT;
      CAPT:    state_n = DONE;
      DONE:    if (out_ready) state_n = ACC;
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACC;
      out_mean    <= '0;
      out_inv_std <= '0;
      out_oor     <= 1'b0;
      var_q       <= '0;
    end else begin
      state <= state_n;
      if (state == CALC) begin
        out_mean <= mean_c;
        var_q    <= var_c;
      end
      if (state == CAPT) begin
        out_inv_std <= lut_out;
        out_oor     <= oor_c;
      end
    end
  end

endmodule

// File: tb/tb_layernorm_stat_unit.sv
// Self-checking bench for layernorm_stat_unit with VEC_LEN=4, a behavioural
// reciprocal-sqrt LUT and a statistics reference model.
module tb_layernorm_stat_unit;

  localparam int VL  = 4;
  localparam int LG  = $clog2(VL);
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lut_in;
  logic [31:0] lut_out = '0;
  logic [31:0] out_mean;
  logic [31:0] out_inv_std;
  logic        out_oor;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  bit bp_hold  = 1'b0;
  bit rand_bp  = 1'b0;

  typedef struct {
    logic [31:0] mean;
    logic [31:0] vr;
    logic [31:0] inv;
    bit          oor;
    int          t;
  } want_t;

  want_t want_q[$];

  layernorm_stat_unit #(
    .BIT_WIDTH (32),
    .VEC_LEN   (VL),
    .FRAC_BITS (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lut_in      (lut_in),
    .lut_out     (lut_out),
    .out_mean    (out_mean),
    .out_inv_std (out_inv_std),
    .out_oor     (out_oor),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External LUT: 1/sqrt(sel/16) in Q16.16 for sel in 4..15, else 0.
  function automatic logic [31:0] lut_fn(input logic [31:0] x);
    int unsigned s;
    s = int'(x >> 12);
    if (s >= 4 && s <= 15) return 32'(longint'($floor(262144.0 / $sqrt(real'(s)))));
    return '0;
  endfunction

  always @(posedge clk) lut_out <= lut_fn(lut_in);

  always @(posedge clk) begin
    #1;
    if (bp_hold) out_ready = 1'b0;
    else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic want_t model(input int v[VL]);
    want_t  w;
    longint sum = 0;
    longint unsigned sq = 0;
    longint ex2, m2, vr;
    int     mean;
    for (int i = 0; i < VL; i++) begin
      sum += longint'(v[i]);
      sq  += longint'(longint'(v[i]) * longint'(v[i]));
    end
    mean = int'(sum >>> LG);
    ex2  = longint'(sq >> (16 + LG));
    m2   = (longint'(mean) * longint'(mean)) >>> 16;
    vr   = ex2 - m2;
    if (vr < 0) vr = 0;
    if (vr > 64'h0000_0000_FFFF_FFFF) vr = 64'h0000_0000_FFFF_FFFF;
    w.mean = mean;
    w.vr   = 32'(vr);
    w.inv  = lut_fn(32'(vr));
    w.oor  = ((vr >> 12) < 4) || ((vr >> 12) > 15);
    w.t    = 0;
    return w;
  endfunction

  // Drives the first n elements of v; a full vector registers a model result.
  task automatic send_vec(input int v[VL], input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    want_t w;
    while (i < n) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = v[i];
        if (in_ready) begin
          if (i == VL - 1) begin
            w   = model(v);
            w.t = cyc;
            want_q.push_back(w);
          end
          i++;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic directed(input int v[VL], input string nm, input longint m,
                          input longint inv, input bit oor);
    bit ok;
    send_vec(v, VL, 1'b0);
    wait_valid(ok);
    if (ok) begin
      chk({nm, "_mean"}, out_mean, m);
      chk({nm, "_inv"}, out_inv_std, inv);
      chk({nm, "_oor"}, out_oor, oor);
    end
  endtask

  // Single compare process: latency, hold stability, and model comparison at handoff.
  initial begin
    bit          pv = 1'b0;
    bit          pr = 1'b0;
    logic [31:0] pm, pi, pl;
    bit          po;
    want_t       w;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 0);
        if (!pv) begin
          if (want_q.size() == 0) chk("spurious_valid", 1, 0);
          else chk("latency", cyc, want_q[0].t + LAT);
        end else if (!pr) begin
          chk("hold_mean", out_mean, pm);
          chk("hold_inv", out_inv_std, pi);
          chk("hold_oor", out_oor, po);
          chk("hold_lut_in", lut_in, pl);
        end
        if (out_ready && want_q.size() > 0) begin
          w = want_q.pop_front();
          chk("mean", out_mean, w.mean);
          chk("lut_in", lut_in, w.vr);
          chk("inv_std", out_inv_std, w.inv);
          chk("oor", out_oor, w.oor);
        end
      end
      pv = out_valid;
      pr = out_ready;
      pm = out_mean;
      pi = out_inv_std;
      po = out_oor;
      pl = lut_in;
    end
  end

  initial begin
    int  v[VL];
    bit  ok;
    int  amp;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready_during", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mean", out_mean, 0);
    chk("rst_inv", out_inv_std, 0);
    chk("rst_lut_in", lut_in, 0);
    chk("rst_oor", out_oor, 0);

    v = '{0, 65536, 0, 65536};
    directed(v, "t1", 32768, 131072, 1'b0);
    chk("t1_lut_in", lut_in, 16384);
    v = '{0, 98304, 0, 98304};
    directed(v, "t2", 49152, 87381, 1'b0);
    chk("t2_lut_in", lut_in, 36864);
    v = '{32768, 32768, 32768, 32768};
    directed(v, "t3", 32768, 0, 1'b1);
    v = '{-65536, 65536, -65536, 65536};
    directed(v, "t4", 0, 0, 1'b1);
    chk("t4_lut_in", lut_in, 65536);

    // Backpressure with ignored in_valid pulses while held.
    @(negedge clk);
    bp_hold = 1'b1;
    v = '{0, 65536, 0, 65536};
    send_vec(v, VL, 1'b0);
    wait_valid(ok);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      in_valid = 1'b1;
      in_data  = 32'($urandom);
    end
    in_valid = 1'b0;
    bp_hold  = 1'b0;
    v = '{0, 98304, 0, 98304};
    directed(v, "after_bp", 49152, 87381, 1'b0);

    // Abort a half-sent vector with reset.
    v = '{0, 65536, 0, 65536};
    send_vec(v, 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_during", in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    directed(v, "after_abort", 32768, 131072, 1'b0);

    // Randomized vectors with input gaps and random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      amp = 1 << $urandom_range(8, 30);
      for (int i = 0; i < VL; i++) begin
        if ($urandom_range(0, 2) == 0) v[i] = int'($urandom_range(0, 32'(amp)));
        else v[i] = int'($urandom_range(0, 32'(2 * longint'(amp)))) - amp;
      end
      send_vec(v, VL, 1'b1);
    end

    for (int k = 0; k < 500 && want_q.size() != 0; k++) @(negedge clk);
    chk("drain", want_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
